// File: rtl/btn_event_conditioner.sv
// Button front end: two-flop synchroniser, per-button debounce, press/release pulses and a press-event FIFO.
// Build with AUTOREPEAT_EN defined to add hold-to-repeat on the buttons selected by REPEAT_MASK.
module btn_event_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               FIFO_DEPTH      = 4,
    parameter int               REPEAT_DELAY    = 20000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b1011
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    output logic             evt_rpt,
    input  logic             evt_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int IDX_W = 2;

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync;
    logic [CNT_W-1:0] db_cnt [N_BTN];
    logic [N_BTN-1:0] toggle;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;
    logic [N_BTN-1:0] rpt_fire;
    logic [N_BTN-1:0] press_rpt;

    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] pend_rpt;
    logic [N_BTN-1:0] push_oh;
    logic [N_BTN-1:0] lost;
    logic [IDX_W-1:0] sel_idx;

    logic [2:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic             full;
    logic             pop;
    logic             push;
    logic [2:0]       push_data;
    logic [2:0]       head_next;
    logic             valid_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_BTN; i++) begin
            toggle[i] = (sync[i] != btn_level[i]) &&
                        (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign rise = toggle & ~btn_level;
    assign fall = toggle & btn_level;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            press_rpt   <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if ((sync[i] == btn_level[i]) || toggle[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
            btn_level   <= btn_level ^ toggle;
            btn_press   <= rise | rpt_fire;
            btn_release <= fall;
            press_rpt   <= rpt_fire;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_cnt [N_BTN];
    logic [N_BTN-1:0]  hold_rep;

    // A repeat falling due on the release edge is swallowed by the !fall term.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (REPEAT_MASK[i] && btn_level[i] && !fall[i]) begin
                if (hold_rep[i]) begin
                    rpt_fire[i] = (hold_cnt[i] == HOLD_W'(REPEAT_PERIOD - 1));
                end else begin
                    rpt_fire[i] = (hold_cnt[i] == HOLD_W'(REPEAT_DELAY - 1));
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_cnt[i] <= '0;
            end
            hold_rep <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!REPEAT_MASK[i] || !btn_level[i] || fall[i]) begin
                    hold_cnt[i] <= '0;
                    hold_rep[i] <= 1'b0;
                end else if (rpt_fire[i]) begin
                    hold_cnt[i] <= '0;
                    hold_rep[i] <= 1'b1;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // Fixed priority: the lowest-index pending button wins the single push slot.
    always_comb begin
        sel_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign push_data = {sel_idx, pend_rpt[sel_idx]};

    always_comb begin
        push_oh = '0;
        for (int i = 0; i < N_BTN; i++) begin
            push_oh[i] = push && (sel_idx == IDX_W'(i));
        end
    end

    assign lost = btn_press & pend & ~push_oh;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend     <= '0;
            pend_rpt <= '0;
            ovf      <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_press[i] && !lost[i]) begin
                    pend[i]     <= 1'b1;
                    pend_rpt[i] <= press_rpt[i];
                end else if (push_oh[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (|lost) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // Handshake: an event transfers on any edge where evt_valid && evt_ready; while
    // evt_valid is high and evt_ready low, evt_code/evt_rpt hold their value.
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop         = evt_valid && evt_ready;
    assign push        = (|pend) && (!full || pop);
    assign wr_ptr_next = wr_ptr + PW'(push);
    assign rd_ptr_next = rd_ptr + PW'(pop);

    // The new head is the entry being written only when it lands in an otherwise empty FIFO.
    always_comb begin
        valid_next = (wr_ptr_next != rd_ptr_next);
        head_next  = '0;
        if (valid_next) begin
            if (push && (rd_ptr_next == wr_ptr)) begin
                head_next = push_data;
            end else begin
                head_next = fifo_mem[rd_ptr_next[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_rpt   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            evt_valid <= valid_next;
            evt_code  <= head_next[2:1];
            evt_rpt   <= head_next[0];
        end
    end

endmodule

// File: tb/tb_btn_event_conditioner.sv
// Bench for btn_event_conditioner: directed table and sequences, then random stimulus
// checked every cycle against a window-based reference model.
module tb_btn_event_conditioner;

    localparam int DB    = 4;
    localparam int DEPTH = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 3;
    localparam logic [3:0] RMASK = 4'b1011;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] btn_raw = '0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_rpt;
    logic       ovf;

    always #5 CLK = ~CLK;

    btn_event_conditioner #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH(DEPTH),
        .REPEAT_DELAY(RDLY),
        .REPEAT_PERIOD(RPER),
        .REPEAT_MASK(RMASK)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .evt_rpt(evt_rpt),
        .evt_ready(evt_ready),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model state, valid for the current cycle
    logic [3:0] raw_hist[$];
    logic [2:0] exp_q[$];
    logic       prev_rdy;
    logic       prev_clr;
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [3:0] m_release;
    logic [3:0] m_rptp;
    logic [3:0] m_pend;
    logic [3:0] m_prpt;
    logic       m_ovf;
    int         rise_t[4];

    typedef struct {
        logic [3:0] raw;
        logic       rdy;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic       vld;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic sync_at(input int t, input int i);
        if (t >= 2 && (t - 2) < raw_hist.size()) return raw_hist[t-2][i];
        return 1'b0;
    endfunction

    task automatic model_reset();
        cyc = 0;
        raw_hist.delete();
        exp_q.delete();
        m_level = '0; m_press = '0; m_release = '0; m_rptp = '0;
        m_pend = '0; m_prpt = '0; m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) rise_t[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] nl;
        logic [3:0] rep;
        logic       pop;
        logic       lost;
        logic       all_diff;
        int         sz;
        int         sel;
        sz  = exp_q.size();
        pop = (sz > 0) && prev_rdy;
        if (pop) void'(exp_q.pop_front());
        sel = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
        if (sel >= 0 && (sz < DEPTH || pop)) begin
            exp_q.push_back({2'(sel), m_prpt[sel]});
            m_pend[sel] = 1'b0;
        end
        lost = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_press[i]) begin
                if (m_pend[i]) lost = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_prpt[i] = m_rptp[i];
                end
            end
        end
        m_ovf = lost ? 1'b1 : (prev_clr ? 1'b0 : m_ovf);
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DB; j++) if (sync_at(cyc - j, i) == m_level[i]) all_diff = 1'b0;
            nl[i] = m_level[i] ^ all_diff;
        end
        rep = '0;
`ifdef AUTOREPEAT_EN
        for (int i = 0; i < 4; i++) begin
            if (RMASK[i] && m_level[i] && nl[i] && (cyc - rise_t[i]) >= RDLY &&
                ((cyc - rise_t[i] - RDLY) % RPER) == 0) rep[i] = 1'b1;
        end
`endif
        for (int i = 0; i < 4; i++) if (nl[i] && !m_level[i]) rise_t[i] = cyc;
        m_press   = (nl & ~m_level) | rep;
        m_release = m_level & ~nl;
        m_rptp    = rep;
        m_level   = nl;
    endtask

    task automatic compare_model();
        chk("m_level", btn_level, m_level);
        chk("m_press", btn_press, m_press);
        chk("m_release", btn_release, m_release);
        chk("m_valid", evt_valid, exp_q.size() > 0);
        chk("m_ovf", ovf, m_ovf);
        if (exp_q.size() > 0) begin
            chk("m_code", evt_code, exp_q[0][2:1]);
            chk("m_rpt", evt_rpt, exp_q[0][0]);
        end
    endtask

    task automatic step(input logic [3:0] raw, input logic rdy, input logic clr);
        btn_raw   = raw;
        evt_ready = rdy;
        ovf_clr   = clr;
        raw_hist.push_back(raw);
        prev_rdy = rdy;
        prev_clr = clr;
        @(posedge CLK);
        #1;
        cyc++;
        model_step();
        compare_model();
    endtask

    task automatic do_reset(input logic [3:0] raw, input int n);
        btn_raw   = raw;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        RST_N     = 1'b0;
        #1;
        chk("rst_level", btn_level, 0);
        chk("rst_press", btn_press, 0);
        chk("rst_release", btn_release, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_rpt", evt_rpt, 0);
        chk("rst_ovf", ovf, 0);
        repeat (n) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        int s;
        int cnt;
        int hold_left[4];
        logic [3:0] rnd_raw;

        // clean rise of button 1: level/press at 6, event at 8, held while not ready
        vecs[0] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[1] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[2] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[3] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[4] = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[5] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd0};
        vecs[6] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd0};
        vecs[7] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1};
        vecs[8] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1};
        vecs[9] = '{4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0};

        #3;
        do_reset(4'b0000, 2);

        for (int k = 0; k < 10; k++) begin
            step(vecs[k].raw, vecs[k].rdy, 1'b0);
            chk("tA_level", btn_level, vecs[k].lvl);
            chk("tA_press", btn_press, vecs[k].prs);
            chk("tA_valid", evt_valid, vecs[k].vld);
            if (vecs[k].vld) chk("tA_code", evt_code, vecs[k].code);
            chk("tA_ovf", ovf, 0);
        end
        for (int k = 0; k < 12; k++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (cyc == 16) chk("tA_release", btn_release, 4'b0010);
        end

        // bounce on button 0 must never reach the level
        for (int k = 0; k < 20; k++) begin
            step({3'b000, (((k / 2) % 2) == 0)}, 1'b1, 1'b0);
            chk("tB_bounce_level", btn_level[0], 0);
            chk("tB_bounce_press", btn_press[0], 0);
        end
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(4'b0001, 1'b1, 1'b0);
            if (btn_press[0]) cnt++;
        end
        chk("tB_single_press", cnt, 1);
        for (int k = 0; k < 14; k++) step(4'b0000, 1'b1, 1'b0);

        // simultaneous rise of buttons 0 and 3
        s = cyc;
        for (int k = 0; k < 12; k++) begin
            step(4'b1001, 1'b1, 1'b0);
            if (cyc == s + 6) chk("tC_press", btn_press, 4'b1001);
            if (cyc == s + 8) begin
                chk("tC_valid0", evt_valid, 1);
                chk("tC_code0", evt_code, 0);
            end
            if (cyc == s + 9) begin
                chk("tC_valid1", evt_valid, 1);
                chk("tC_code1", evt_code, 3);
            end
            if (cyc == s + 10) chk("tC_empty", evt_valid, 0);
            chk("tC_ovf", ovf, 0);
        end
        for (int k = 0; k < 20; k++) step(4'b0000, 1'b1, 1'b0);

        // six presses of button 2 with no consumer: 4 queued, 1 pending, 1 lost
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 7; k++) step(4'b0100, 1'b0, 1'b0);
            for (int k = 0; k < 7; k++) step(4'b0000, 1'b0, 1'b0);
            chk("tD_ovf", ovf, (p == 5));
        end
        chk("tD_valid", evt_valid, 1);
        chk("tD_code", evt_code, 2);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (evt_valid) cnt++;
            step(4'b0000, 1'b1, 1'b0);
        end
        chk("tD_pops", cnt, 5);
        chk("tD_drained", evt_valid, 0);
        chk("tD_ovf_sticky", ovf, 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("tD_ovf_clr", ovf, 0);

        // reset with three queued events, buttons held through it
        for (int k = 0; k < 10; k++) step(4'b1011, 1'b0, 1'b0);
        chk("tE_queued", evt_valid, 1);
        do_reset(4'b1011, 3);
        for (int k = 0; k < 10; k++) begin
            step(4'b1011, 1'b1, 1'b0);
            if (cyc == 1) chk("tE_discarded", evt_valid, 0);
            if (cyc == 5) chk("tE_no_early", btn_level, 0);
            if (cyc == 6) chk("tE_fresh_press", btn_press, 4'b1011);
            if (cyc == 8) chk("tE_code0", evt_code, 0);
            if (cyc == 9) chk("tE_code1", evt_code, 1);
            if (cyc == 10) chk("tE_code3", evt_code, 3);
        end
        for (int k = 0; k < 20; k++) step(4'b0000, 1'b1, 1'b0);

`ifdef AUTOREPEAT_EN
        s = cyc;
        for (int k = 0; k < 30; k++) begin
            step(4'b0001, 1'b1, 1'b0);
            chk("tF_rpt_press", btn_press[0],
                ((cyc - s) == 6) || ((cyc - s) >= 16 && ((cyc - s - 16) % 3) == 0));
            if ((cyc - s) == 8) chk("tF_first_rpt", evt_rpt, 0);
            if ((cyc - s) == 18) begin
                chk("tF_rpt_valid", evt_valid, 1);
                chk("tF_rpt_flag", evt_rpt, 1);
            end
        end
        for (int k = 0; k < 14; k++) step(4'b0000, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'b0100, 1'b1, 1'b0);
            if (btn_press[2]) cnt++;
        end
        chk("tF_change_no_rpt", cnt, 1);
        for (int k = 0; k < 14; k++) step(4'b0000, 1'b1, 1'b0);
`endif

        rnd_raw = '0;
        for (int i = 0; i < 4; i++) hold_left[i] = 0;
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset(rnd_raw, 2);
            for (int i = 0; i < 4; i++) begin
                if (hold_left[i] == 0) begin
                    rnd_raw[i]   = 1'($urandom_range(0, 1));
                    hold_left[i] = $urandom_range(1, 14);
                end else begin
                    hold_left[i]--;
                end
            end
            step(rnd_raw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
